lsu_mem_bridge: RTL and testbench

- Load/store bridge between the multicycle core datapath and a grant/valid data memory port.
- Sits downstream of the control FSM and datapath.
- Accepts one load or store request at a time and drives a word-aligned memory request with byte enables.
- Returns aligned, sign- or zero-extended load data, and holds busy so the control FSM stalls until the access completes.

---
 rtl/lsu_mem_bridge_pkg.sv | 34 +++
 rtl/lsu_mem_bridge_if.sv | 36 +++
 rtl/lsu_align.sv | 45 ++++
 rtl/lsu_mem_bridge.sv | 138 +++++++++++++
 tb/tb_lsu_mem_bridge.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_bridge_pkg.sv
// Shared definitions for the load/store memory bridge: funct3 size/sign
// fields, bridge state encoding and access legality helpers.
package lsu_mem_bridge_pkg;

    // funct3[1:0] selects the access size, funct3[2] marks unsigned loads
    localparam logic [1:0] SZ_B      = 2'b00;
    localparam logic [1:0] SZ_H      = 2'b01;
    localparam logic [1:0] SZ_W      = 2'b10;
    localparam int         F3_UNS    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Loads: LB LH LW LBU LHU. Stores: SB SH SW.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3[F3_UNS] == 1'b0) && (f3[1:0] != 2'b11);
        return (f3[1:0] != 2'b11) && !(f3[F3_UNS] && (f3[1:0] == SZ_W));
    endfunction

    // Halfword needs addr[0]==0, word needs addr[1:0]==0
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_bridge_if.sv
// Core request/response and data-memory port bundle for lsu_mem_bridge.
// slave = the bridge, master = core plus memory side driving it.
interface lsu_mem_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
               mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Lane alignment for the bridge: byte enables, store data replication and
// load data shift plus sign/zero extension. Purely combinational.
// Misaligned low address bits are dropped: halfwords use addr[1], words lane 0.
module lsu_align
    import lsu_mem_bridge_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [4:0]  w_sh;
    logic [31:0] w_shifted;

    // Per-size lane select and data formatting
    always_comb begin
        o_be      = 4'b1111;
        o_wdata   = i_wdata;
        w_sh      = 5'd0;
        case (i_funct3[1:0])
            SZ_B: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                w_sh    = {i_off, 3'b000};
            end
            SZ_H: begin
                o_be    = 4'b0011 << {i_off[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                w_sh    = {i_off[1], 4'b0000};
            end
            default: ;
        endcase
        w_shifted = i_rdata >> w_sh;
        case (i_funct3[1:0])
            SZ_B:    o_rdata = i_funct3[F3_UNS] ? {24'd0, w_shifted[7:0]}
                                                : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_H:    o_rdata = i_funct3[F3_UNS] ? {16'd0, w_shifted[15:0]}
                                                : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: o_rdata = w_shifted;
        endcase
    end
endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: one request at a time from the core, word-aligned
// memory request with byte enables, extended load data back, busy while
// the access is in flight. TIMEOUT bounds cycles spent in REQ+WAIT.
// Build option LSU_MISALIGN_FAULT_EN: reject misaligned half/word accesses
// with rsp_err instead of silently dropping the low address bits.
module lsu_mem_bridge
    import lsu_mem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    lsu_mem_bridge_if.slave bus
);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_ready, r_busy, r_mem_req;
    logic              r_rsp_valid, r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [31:0]       r_addr, r_wdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_reject, w_tmo;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata, w_rdata_ext;

    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_off    (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (bus.mem_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_rdata_ext)
    );

`ifdef LSU_MISALIGN_FAULT_EN
    assign w_reject = !f3_legal(bus.req_we, bus.req_funct3)
                    || f3_misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
    assign w_reject = !f3_legal(bus.req_we, bus.req_funct3);
`endif

    // Fires on the TIMEOUT-th cycle spent in REQ+WAIT
    assign w_tmo = (TIMEOUT != 0) && (r_cnt == TMO_LAST);

    assign bus.req_ready = r_ready & ~rst;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_req & r_we;
    assign bus.mem_addr  = r_mem_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign bus.mem_be    = r_mem_req ? w_be : 4'd0;
    assign bus.mem_wdata = r_mem_req ? w_wdata : 32'd0;

    // Bridge FSM with timeout counter, capture registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_cnt       <= '0;
        end else begin
            // Response fields only live for the single RESP cycle
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_ready) begin
                        r_we     <= bus.req_we;
                        r_funct3 <= bus.req_funct3;
                        r_addr   <= bus.req_addr;
                        r_wdata  <= bus.req_wdata;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        if (w_reject) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state   <= ST_REQ;
                            r_mem_req <= 1'b1;
                        end
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A grant on the last budgeted cycle still times out
                    if (w_tmo) begin
                        r_state     <= ST_RESP;
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end else if (bus.mem_gnt) begin
                        r_state   <= ST_WAIT;
                        r_mem_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Data arriving on the last budgeted cycle is still taken
                    if (bus.mem_rvalid) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_we ? 32'd0 : w_rdata_ext;
                    end else if (w_tmo) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Self-checking bench for lsu_mem_bridge: directed cases then randomized
// requests with randomized grant/rvalid delays, against a byte-level model.
module tb_lsu_mem_bridge;
    localparam int TMO = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    lsu_mem_bridge_if bus ();

    lsu_mem_bridge #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
        end
    endtask

    function automatic int sz_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (we) ok = (f3 inside {3'd0, 3'd1, 3'd2});
        else    ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_FAULT_EN
        if (ok && (int'(a[1:0]) % sz_bytes(f3)) != 0) ok = 0;
`endif
        return ok;
    endfunction

    // Byte lane the access lands on after dropping misaligned low bits
    function automatic int ref_lane(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = sz_bytes(f3);
        return (int'(a[1:0]) / n) * n;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] b;
        b = 4'd0;
        for (int i = 0; i < sz_bytes(f3); i++) b[ref_lane(f3, a) + i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = sz_bytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v, m;
        int n;
        n = sz_bytes(f3);
        v = rd >> (8 * ref_lane(f3, a));
        m = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = v & m;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~m;
        return v;
    endfunction

    task automatic wait_ready();
        int w;
        w = 0;
        while (!bus.req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    endtask

    // One request; gnt after dg REQ cycles, rvalid dr cycles after entering WAIT.
    // Cycle k counts negedges after the accepting edge.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int dg, input int dr);
        bit ok;
        int req_last, rsp_k, rv_k, kend;
        logic e_err;
        logic [31:0] e_rdata;
        ok   = ref_legal(we, f3, a);
        rv_k = dg + dr + 2;
        if (!ok) begin
            rsp_k = 1; req_last = 0; e_err = 1'b1; e_rdata = 32'd0;
        end else if (rv_k <= TMO) begin
            rsp_k = rv_k + 1; req_last = dg + 1; e_err = 1'b0;
            e_rdata = we ? 32'd0 : ref_load(f3, a, rd);
        end else begin
            rsp_k = TMO + 1; req_last = (dg + 1 < TMO) ? dg + 1 : TMO;
            e_err = 1'b1; e_rdata = 32'd0;
        end
        kend = ((rsp_k > rv_k) ? rsp_k : rv_k) + 1;
        wait_ready();
        if (!bus.req_ready) return;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        for (int k = 1; k <= kend; k++) begin
            chk("mem_req",   {31'd0, bus.mem_req},   {31'd0, k <= req_last});
            chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, k == rsp_k});
            chk("rsp_err",   {31'd0, bus.rsp_err},   {31'd0, (k == rsp_k) && e_err});
            chk("rsp_rdata", bus.rsp_rdata,          (k == rsp_k) ? e_rdata : 32'd0);
            chk("busy",      {31'd0, bus.busy},      {31'd0, k <= rsp_k});
            chk("req_ready", {31'd0, bus.req_ready}, {31'd0, k > rsp_k});
            if (k <= req_last) begin
                chk("mem_addr",  bus.mem_addr,           a & 32'hFFFF_FFFC);
                chk("mem_we",    {31'd0, bus.mem_we},    {31'd0, we});
                chk("mem_be",    {28'd0, bus.mem_be},    {28'd0, ref_be(f3, a)});
                if (we) chk("mem_wdata", bus.mem_wdata, ref_wdata(f3, wd));
            end
            bus.mem_gnt    = (k == dg + 1);
            // Stray rvalid while still waiting for grant must be ignored
            bus.mem_rvalid = (k == rv_k) || (k <= dg && $urandom_range(0, 1) == 1);
            bus.mem_rdata  = (k == rv_k) ? rd : $urandom;
            @(negedge clk);
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
    endtask

    // Reset while a load sits in WAIT: nothing completes, bridge recovers
    task automatic run_reset_mid();
        wait_ready();
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h200;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_pre_mem_req", {31'd0, bus.mem_req}, 32'd1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("rst_pre_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy",      {31'd0, bus.busy},      32'd0);
            chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("rst_mem_req",   {31'd0, bus.mem_req},   32'd0);
            chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h1234_5678;
            @(negedge clk);
        end
        rst = 1'b0;
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("post_rst_busy",      {31'd0, bus.busy},      32'd0);
            @(negedge clk);
        end
    endtask

    function automatic logic [2:0] pick_f3(input logic we);
        if ($urandom_range(0, 9) == 0) return 3'($urandom_range(0, 7));
        if (we) return 3'($urandom_range(0, 2));
        case ($urandom_range(0, 4))
            0: return 3'd0;
            1: return 3'd1;
            2: return 3'd2;
            3: return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        int          dg, dr;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("reset_busy",      {31'd0, bus.busy},      32'd0);
        chk("reset_mem_req",   {31'd0, bus.mem_req},   32'd0);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata,          32'd0);
        chk("reset_mem_addr",  bus.mem_addr,           32'd0);
        chk("reset_mem_be",    {28'd0, bus.mem_be},    32'd0);
        rst = 1'b0;

        run_txn(1'b0, 3'b010, 32'h100, 32'd0,        32'hDEAD_BEEF, 0, 0);
        run_txn(1'b0, 3'b000, 32'h103, 32'd0,        32'h80FF_0000, 0, 0);
        run_txn(1'b0, 3'b100, 32'h103, 32'd0,        32'h80FF_0000, 0, 0);
        run_txn(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 32'd0,        3, 0);
        run_txn(1'b0, 3'b010, 32'h300, 32'd0,        32'hCAFE_F00D, 0, 10);
        run_txn(1'b0, 3'b011, 32'h100, 32'd0,        32'd0,         0, 0);
        run_txn(1'b1, 3'b110, 32'h104, 32'h1111_2222, 32'd0,        0, 0);
        run_txn(1'b0, 3'b010, 32'h101, 32'd0,        32'h0BAD_F00D, 0, 0);
        run_txn(1'b0, 3'b101, 32'h203, 32'd0,        32'h8001_7FFF, 1, 1);
        run_txn(1'b0, 3'b001, 32'h202, 32'd0,        32'h8001_7FFF, 2, 2);
        run_txn(1'b1, 3'b010, 32'h400, 32'h5555_AAAA, 32'd0,        5, 0);
        run_txn(1'b1, 3'b000, 32'h401, 32'h0000_00C3, 32'd0,        TMO + 2, 0);
        run_reset_mid();
        run_txn(1'b0, 3'b010, 32'h500, 32'd0,        32'h0123_4567, 0, 0);

        repeat (150) begin
            we = 1'($urandom_range(0, 1));
            f3 = pick_f3(we);
            if ($urandom_range(0, 5) == 0) begin
                dg = $urandom_range(0, TMO + 1);
                dr = $urandom_range(0, TMO + 1);
            end else begin
                dg = $urandom_range(0, 2);
                dr = $urandom_range(0, 2);
            end
            run_txn(we, f3, $urandom, $urandom, $urandom, dg, dr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
